// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: strobes from decode/branch resolution and the registered fetch-side outputs.
interface pc_sequencer_if #(
    parameter int IP_WIDTH = 10
);
    logic                stall, halt, jump, call, ret, branch;
    logic [IP_WIDTH-1:0] target;
    logic [5:0]          branch_offset;
    logic [IP_WIDTH-1:0] ip;
    logic                ip_valid, flush, halted, stack_error;
    modport master (
        output stall, halt, jump, call, ret, branch, target, branch_offset,
        input  ip, ip_valid, flush, halted, stack_error
    );
    modport slave (
        input  stall, halt, jump, call, ret, branch, target, branch_offset,
        output ip, ip_valid, flush, halted, stack_error
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side IP controller with relative/absolute redirects, return stack and post-redirect flush.
module pc_sequencer #(
    parameter int IP_WIDTH     = 10,
    parameter int STACK_DEPTH  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic           Clock,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    localparam int SW = $clog2(STACK_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
    state_t              state, state_n;
    logic [IP_WIDTH-1:0] ip, ip_n, tgt, seq_ip, br_tgt, br_mag, pop_addr;
    logic [IP_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SW:0]         sp, sp_n;
    logic [2:0]          cnt, cnt_n;
    logic                ip_valid, ip_valid_n, flush, flush_n, halted, halted_n;
    logic                stack_error, stack_error_n;
    logic                redirect, go_halt, push, full, empty;
    assign seq_ip   = bus.stall ? ip : ip + IP_WIDTH'(1);
    assign br_mag   = IP_WIDTH'(bus.branch_offset[4:0]);
    assign br_tgt   = bus.branch_offset[5] ? ip - br_mag : ip + br_mag;
    // Depth is a power of two, so the MSB of the pointer alone marks "full".
    assign full     = sp[SW];
    assign empty    = (sp == '0);
    assign pop_addr = stack_mem[SW'(sp - (SW+1)'(1))];
    always_comb begin
        state_n       = state;
        ip_n          = ip;
        ip_valid_n    = ip_valid;
        flush_n       = flush;
        halted_n      = halted;
        stack_error_n = stack_error;
        sp_n          = sp;
        cnt_n         = cnt;
        redirect      = 1'b0;
        go_halt       = 1'b0;
        push          = 1'b0;
        tgt           = ip;
        case (state)
            IDLE: begin
                state_n    = RUN;
                ip_n       = '0;
                ip_valid_n = 1'b1;
            end
            RUN: begin
                if (bus.halt) begin
                    go_halt = 1'b1;
                end else if (bus.jump) begin
                    redirect = 1'b1;
                    tgt      = bus.target;
                end else if (bus.call) begin
                    go_halt       = full;
                    stack_error_n = stack_error | full;
                    push          = !full;
                    redirect      = !full;
                    sp_n          = full ? sp : sp + (SW+1)'(1);
                    tgt           = bus.target;
                end else if (bus.ret) begin
                    go_halt       = empty;
                    stack_error_n = stack_error | empty;
                    redirect      = !empty;
                    sp_n          = empty ? sp : sp - (SW+1)'(1);
                    tgt           = pop_addr;
                end else if (bus.branch) begin
                    redirect = 1'b1;
                    tgt      = br_tgt;
                end else begin
                    ip_n = seq_ip;
                end
            end
            FLUSH: begin
                ip_n    = seq_ip;
                cnt_n   = cnt - 3'd1;
                flush_n = (cnt != 3'd1);
                state_n = (cnt != 3'd1) ? FLUSH : RUN;
            end
            default: ;
        endcase
        if (redirect) begin
            ip_n    = tgt;
            flush_n = 1'b1;
            cnt_n   = 3'(FLUSH_CYCLES);
            state_n = FLUSH;
        end
        if (go_halt) begin
            state_n    = HALT;
            ip_valid_n = 1'b0;
            halted_n   = 1'b1;
        end
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            ip          <= '0;
            ip_valid    <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
            stack_error <= 1'b0;
            sp          <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            ip          <= ip_n;
            ip_valid    <= ip_valid_n;
            flush       <= flush_n;
            halted      <= halted_n;
            stack_error <= stack_error_n;
            sp          <= sp_n;
            cnt         <= cnt_n;
        end
    end
    // Storage needs no reset: an empty pointer makes every entry unreachable.
    always_ff @(posedge Clock) begin
        if (push) stack_mem[sp[SW-1:0]] <= ip + IP_WIDTH'(1);
    end
    assign bus.ip          = ip;
    assign bus.ip_valid    = ip_valid;
    assign bus.flush       = flush;
    assign bus.halted      = halted;
    assign bus.stack_error = stack_error;
endmodule
